// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the single-cycle datapath and a variable-latency data bus.
// Sizes/aligns the access, drives registered bus signals, stalls the core until ack or timeout.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] LP_TO = TIMEOUT[7:0];

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_bus_req, r_bus_we, r_memerr, r_is_load;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]  r_bus_be;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;

  logic        w_access, w_store, w_legal, w_misalign, w_go, w_bad, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request decode: a simultaneous read+write is treated as a store.
  always_comb begin
    w_access   = MemRead | MemWrite;
    w_store    = MemWrite;
    w_legal    = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~w_store;
      default:                w_legal = 1'b0;
    endcase
    w_misalign = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((Funct3[1:0] == 2'b10) & (|ALUResult[1:0]));
    w_go       = w_access & w_legal & ~w_misalign;
    w_bad      = w_access & ~(w_legal & ~w_misalign);
    w_be       = 4'b1111;
    w_wdata    = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
    if (!w_store) w_wdata = '0;
  end

  // Load lane selection uses the address offset latched at issue.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = (r_state == S_REQ) & ~bus_ack & (r_cnt == LP_TO);
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_REQ;
      S_REQ:   if (bus_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_memerr    <= 1'b0;
      r_cnt       <= '0;
      r_lane      <= '0;
      r_f3        <= '0;
      r_is_load   <= 1'b0;
    end else begin
      r_memerr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rdata <= '0;
          if (w_go) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_store;
            r_bus_addr  <= {ALUResult[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_cnt       <= 8'd1;
            r_lane      <= ALUResult[1:0];
            r_f3        <= Funct3;
            r_is_load   <= ~w_store;
          end else if (w_bad) begin
            r_memerr <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_rdata   <= r_is_load ? w_load : '0;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_rdata   <= '0;
            r_memerr  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_rdata <= '0;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stall is gated by reset so an asserted reset releases the core without a clock edge.
  assign Stall     = reset & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));
  assign ReadData  = r_rdata;
  assign MemErr    = r_memerr;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed, table-driven bench for lsu_bus_bridge plus multi-cycle sequences (wait states, timeout, reset).
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, MemErr, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  lsu_bus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MemErr(MemErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = '0; WriteData = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wdata;
    #1;
    chk({s, " stall_issue"}, 32'(Stall), 32'(!v.err));
    if (v.err) begin
      @(negedge clk);
      chk({s, " err_pulse"}, 32'(MemErr), 32'd1);
      chk({s, " err_noreq"}, 32'(bus_req), 32'd0);
      chk({s, " err_rdata"}, ReadData, 32'd0);
      idle_inputs();
      @(negedge clk);
      chk({s, " err_clear"}, 32'(MemErr), 32'd0);
    end else begin
      @(negedge clk);
      chk({s, " req"}, 32'(bus_req), 32'd1);
      chk({s, " addr"}, bus_addr, {v.addr[31:2], 2'b00});
      chk({s, " be"}, 32'(bus_be), 32'(v.be));
      chk({s, " we"}, 32'(bus_we), 32'(v.wr));
      if (v.wr) chk({s, " wdata"}, bus_wdata, v.exp_wdata);
      chk({s, " stall_req"}, 32'(Stall), 32'd1);
      chk({s, " rdata_req"}, ReadData, 32'd0);
      bus_ack = 1'b1; bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack = 1'b0;
      chk({s, " rdata_done"}, ReadData, v.exp_rdata);
      chk({s, " stall_done"}, 32'(Stall), 32'd0);
      chk({s, " req_done"}, 32'(bus_req), 32'd0);
      chk({s, " noerr"}, 32'(MemErr), 32'd0);
      @(negedge clk);
      chk({s, " no_reissue"}, 32'(bus_req), 32'd0);
      chk({s, " rdata_idle"}, ReadData, 32'd0);
      idle_inputs();
      #1;
      chk({s, " stall_idle"}, 32'(Stall), 32'd0);
    end
  endtask

  initial begin
    int unsigned stalls;
    int unsigned reqs;

    //          rd    wr    f3      addr       wdata         rdata        err   be       exp_wdata     exp_rdata
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80AA55CC, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80AA55CC, 1'b0, 4'b1000, 32'h0,        32'h00000080};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80AA55CC, 1'b0, 4'b1100, 32'h0,        32'hFFFF80AA};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80AA55CC, 1'b0, 4'b0011, 32'h0,        32'h000055CC};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h80AA55CC, 1'b0, 4'b0010, 32'h0,        32'h00000055};
    vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'h56785678, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h203, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h200, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h104, 32'h11223344, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'h11223344, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,        32'h01234567, 1'b0, 4'b1111, 32'h0,        32'h01234567};

    idle_inputs();
    bus_ack = 1'b0; bus_rdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst ReadData", ReadData, 32'd0);
    chk("rst Stall", 32'(Stall), 32'd0);
    chk("rst MemErr", 32'(MemErr), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // LW with three REQ cycles before ack.
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h100;
    stalls = 0;
    #1; if (Stall) stalls++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lw_wait req", 32'(bus_req), 32'd1);
      chk("lw_wait addr", bus_addr, 32'h100);
      chk("lw_wait be", 32'(bus_be), 32'hF);
      chk("lw_wait rdata", ReadData, 32'd0);
      if (Stall) stalls++;
      if (k == 3) begin bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("lw_wait done rdata", ReadData, 32'hDEADBEEF);
    chk("lw_wait done stall", 32'(Stall), 32'd0);
    chk("lw_wait stall cycles", stalls, 32'd4);
    @(negedge clk);
    chk("lw_wait idle rdata", ReadData, 32'd0);
    chk("lw_wait idle req", 32'(bus_req), 32'd0);
    idle_inputs();

    // SW with no ack: times out after 4 REQ cycles, late ack ignored.
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400; WriteData = 32'h5A5A0F0F;
    reqs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_req) reqs++;
      chk("to stall", 32'(Stall), 32'd1);
      chk("to noerr", 32'(MemErr), 32'd0);
    end
    chk("to req cycles", reqs, 32'd4);
    @(negedge clk);
    chk("to req drop", 32'(bus_req), 32'd0);
    chk("to memerr", 32'(MemErr), 32'd1);
    chk("to stall done", 32'(Stall), 32'd0);
    chk("to rdata", ReadData, 32'd0);
    idle_inputs();
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("to late ack memerr", 32'(MemErr), 32'd0);
    chk("to late ack req", 32'(bus_req), 32'd0);
    chk("to late ack rdata", ReadData, 32'd0);
    bus_ack = 1'b0;

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h500;
    @(negedge clk);
    chk("rst_mid req before", 32'(bus_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid req", 32'(bus_req), 32'd0);
    chk("rst_mid stall", 32'(Stall), 32'd0);
    idle_inputs();
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid ack ignored rdata", ReadData, 32'd0);
    chk("rst_mid ack ignored req", 32'(bus_req), 32'd0);
    chk("rst_mid stall after", 32'(Stall), 32'd0);
    bus_ack = 1'b0;
    run_vec(vecs[13], 99);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the single-cycle datapath and an external data-memory bus with variable latency.
- Consumes the datapath's address (ALUResult), store data (WriteData) and control (MemRead/MemWrite/Funct3). Returns the formatted ReadData and a Stall that freezes PC and register writeback until the bus access completes.
- Handles byte/half/word sizing, sign/zero extension, byte enables, misalignment and bus timeout.

Parameters:
TIMEOUT, 255, maximum cycles spent waiting for bus_ack before aborting the access with an error; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  core requests a load this cycle
MemWrite  input  1  core requests a store this cycle
Funct3  input  3  access size/sign from Instr[14:12]
ALUResult  input  32  byte address
WriteData  input  32  store data (rs2)
ReadData  output  32  sign/zero-extended load result to the result mux
Stall  output  1  hold PC and suppress RegWrite while 1
MemErr  output  1  one-cycle pulse: misaligned, illegal Funct3 or timeout
bus_req  output  1  bus request, registered
bus_we  output  1  1 = write, registered
bus_addr  output  32  word address {ALUResult[31:2],2'b00}, registered
bus_be  output  4  byte enables, registered
bus_wdata  output  32  lane-replicated store data, registered
bus_ack  input  1  bus completes the access this cycle
bus_rdata  input  32  read word, valid when bus_ack=1

Behaviour:
- Reset (async, reset=0): state=IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, ReadData register, MemErr and the timeout counter all 0. Stall=0. An in-flight access is abandoned; a bus_ack arriving after reset deasserts is ignored.
- FSM states:
  - IDLE
    - access = MemRead|MemWrite. If both are 1, treat as a store.
    - Legal sizes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other Funct3 is illegal.
    - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
    - Legal, aligned access: Stall=1 combinationally in the same cycle. Register bus outputs, bus_req=1, go to REQ.
    - Illegal or misaligned access: Stall=0, no bus activity, ReadData=0, MemErr=1 registered (visible the next cycle for one cycle), stay in IDLE.
  - REQ
    - Stall=1. bus_req and all bus_* outputs held stable until ack. Counter increments each cycle.
    - On bus_ack=1: capture the formatted load data, bus_req=0, go to DONE.
    - If the counter reaches TIMEOUT with no ack: bus_req=0, ReadData=0, MemErr=1 for one cycle, go to DONE.
    - bus_ack in the first REQ cycle is legal (zero-wait bus).
  - DONE
    - Stall=0, ReadData=captured value. The core commits and advances at the end of this cycle.
    - Next state is always IDLE. The still-presented access is not reissued.
    - bus_ack in IDLE or DONE is ignored.
- Latency: a legal access occupies at least 3 cycles (IDLE, REQ+ack, DONE). Stall is asserted for N+1 cycles, where N is the number of REQ cycles.
- Store formatting:
  - SB: bus_wdata={4{WriteData[7:0]}}, bus_be=4'b0001<<addr[1:0].
  - SH: bus_wdata={2{WriteData[15:0]}}, bus_be=addr[1]?4'b1100:4'b0011.
  - SW: bus_wdata=WriteData, bus_be=4'b1111.
- Load formatting: select the byte/half lane with addr[1:0] latched at issue. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Loads drive bus_be for the accessed lanes, same as stores.
- ReadData is 0 whenever no load result is being presented (IDLE, REQ, store DONE).

Test Plan:
- LW addr=0x100, bus acks on the 3rd REQ cycle with bus_rdata=0xDEADBEEF → bus_addr=0x100, bus_be=4'hF, Stall high for 4 cycles, ReadData=0xDEADBEEF in DONE only.
- LB addr=0x103 and LBU addr=0x103, bus_rdata=0x80AA55CC, ack in the first REQ cycle → ReadData=0xFFFFFF80 (LB) and 0x00000080 (LBU); bus_be=4'b1000.
- SH addr=0x202, WriteData=0x12345678 → bus_we=1, bus_wdata=0x56785678, bus_be=4'b1100, held stable until ack.
- LW addr=0x101 and Funct3=011 → no bus_req, Stall=0, MemErr pulses 1 cycle, FSM stays IDLE.
- TIMEOUT=4, SW with no ack → bus_req high 4 cycles then drops, MemErr pulse, DONE then IDLE; a late ack is ignored.
- reset driven low mid-REQ → bus_req=0 and Stall=0 immediately without a clock edge; a subsequent ack is ignored and the next access starts cleanly.
